// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, bit-centre sampling FSM and a
// one-entry output buffer with valid/ready handshake plus frame/overrun pulses.
module uart_rx #(
    parameter int FREQ = 27_000_000,
    parameter int BAUD = 115200
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int CPB  = FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx: FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_ovr;
    logic            r_rx_p0;
    logic            r_rx_p1;
    logic            w_rx_s;

    // Synchroniser stages
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rx_p0 <= 1'b1;
            r_rx_p1 <= 1'b1;
        end else begin
            r_rx_p0 <= uart_rx_i;
            r_rx_p1 <= r_rx_p0;
        end
    end

    assign w_rx_s = r_rx_p1;

    // Shift register holds only data; stale bits are overwritten by every frame
    always_ff @(posedge clk_i) begin
        if (r_state == S_DATA && r_timer == T_FULL) begin
            r_shift[r_idx] <= w_rx_s;
        end
    end

    // Framing FSM and output buffer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    // The detecting cycle is the first tick of the start bit
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_timer <= TW'(1);
                    end else begin
                        r_timer <= '0;
                    end
                end
                S_START: begin
                    if (r_timer == T_HALF) begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_timer <= '0;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == T_FULL) begin
                        r_timer <= '0;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == T_FULL) begin
                        r_timer <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            if (!r_valid || ready_i) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_state <= S_WAIT_HIGH;
                            r_ferr  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=4: frame timing, back-to-back, glitch,
// framing error, overrun, same-edge consume/load and mid-frame reset.
module tb_uart_rx;
    localparam int CPB = 4;

    logic       clk;
    logic       rstn;
    logic       line;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int n_vec;
    int n_err;
    int cyc;
    int t0;

    int         v_hi;
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    int         ferr_cnt;
    int         ferr_cyc;
    int         ovr_cnt;
    int         ovr_cyc;
    int         both_cnt;

    uart_rx #(.FREQ(460800), .BAUD(115200)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .uart_rx_i   (line),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_o) v_hi++;
        if (valid_o && ready_i) begin
            acc_q.push_back(data_o);
            acc_cyc.push_back(cyc);
        end
        if (frame_err_o) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (overrun_o) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (frame_err_o && overrun_o) both_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        v_hi = 0;
        acc_q.delete();
        acc_cyc.delete();
        ferr_cnt = 0;
        ferr_cyc = -1;
        ovr_cnt  = 0;
        ovr_cyc  = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        line = 1'b0;
        t0   = cyc + 1;
        repeat (CPB) wait_cycle();
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) wait_cycle();
        end
        line = stop;
        repeat (CPB) wait_cycle();
    endtask

    function automatic logic [7:0] acc_at(input int k);
        return (acc_q.size() > k) ? acc_q[k] : 8'hxx;
    endfunction

    function automatic int acc_cyc_at(input int k);
        return (acc_cyc.size() > k) ? acc_cyc[k] : -1;
    endfunction

    task automatic test_reset();
        rstn    = 1'b0;
        line    = 1'b1;
        ready_i = 1'b1;
        repeat (3) wait_cycle();
        n_vec++;
        if ({data_o, valid_o, frame_err_o, overrun_o} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b, want all 0",
                     data_o, valid_o, frame_err_o, overrun_o);
        end
        rstn = 1'b1;
        repeat (4) wait_cycle();
        clear_mon();
    endtask

    task automatic test_single();
        int ts;
        clear_mon();
        ready_i = 1'b1;
        send_frame(8'hA5, 1'b1);
        ts = t0;
        repeat (6) wait_cycle();
        n_vec++;
        if (acc_at(0) !== 8'hA5) begin
            n_err++; $display("FAIL single_data: got %h want a5", acc_at(0));
        end
        n_vec++;
        if (acc_cyc_at(0) !== ts + 39) begin
            n_err++; $display("FAIL single_latency: got cycle %0d want %0d", acc_cyc_at(0), ts + 39);
        end
        n_vec++;
        if (v_hi !== 1) begin
            n_err++; $display("FAIL single_valid_width: got %0d cycles want 1", v_hi);
        end
        n_vec++;
        if (ferr_cnt + ovr_cnt !== 0) begin
            n_err++; $display("FAIL single_no_err: got %0d pulses want 0", ferr_cnt + ovr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int ta;
        clear_mon();
        ready_i = 1'b1;
        send_frame(8'h00, 1'b1);
        ta = t0;
        send_frame(8'hFF, 1'b1);
        repeat (6) wait_cycle();
        n_vec++;
        if (acc_q.size() !== 2 || acc_at(0) !== 8'h00 || acc_at(1) !== 8'hFF) begin
            n_err++; $display("FAIL b2b_data: got n=%0d %h %h want 2 00 ff",
                              acc_q.size(), acc_at(0), acc_at(1));
        end
        n_vec++;
        if (acc_cyc_at(0) !== ta + 39 || acc_cyc_at(1) !== ta + 79) begin
            n_err++; $display("FAIL b2b_spacing: got cycles %0d %0d want %0d %0d",
                              acc_cyc_at(0), acc_cyc_at(1), ta + 39, ta + 79);
        end
        n_vec++;
        if (v_hi !== 2) begin
            n_err++; $display("FAIL b2b_valid_cycles: got %0d want 2", v_hi);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        ready_i = 1'b1;
        line = 1'b0;
        wait_cycle();
        line = 1'b1;
        repeat (20) wait_cycle();
        n_vec++;
        if (v_hi !== 0 || ferr_cnt !== 0) begin
            n_err++; $display("FAIL glitch_quiet: got valid=%0d ferr=%0d want 0 0", v_hi, ferr_cnt);
        end
        send_frame(8'h5A, 1'b1);
        repeat (6) wait_cycle();
        n_vec++;
        if (acc_q.size() !== 1 || acc_at(0) !== 8'h5A) begin
            n_err++; $display("FAIL glitch_next_frame: got n=%0d %h want 1 5a", acc_q.size(), acc_at(0));
        end
    endtask

    task automatic test_frame_err();
        int ts;
        clear_mon();
        ready_i = 1'b1;
        send_frame(8'h3C, 1'b0);
        ts = t0;
        repeat (20) wait_cycle();
        line = 1'b1;
        repeat (8) wait_cycle();
        n_vec++;
        if (ferr_cnt !== 1 || ferr_cyc !== ts + 39) begin
            n_err++; $display("FAIL ferr_pulse: got %0d pulses at %0d want 1 at %0d",
                              ferr_cnt, ferr_cyc, ts + 39);
        end
        n_vec++;
        if (v_hi !== 0) begin
            n_err++; $display("FAIL ferr_no_valid: got %0d valid cycles want 0", v_hi);
        end
        send_frame(8'h11, 1'b1);
        repeat (6) wait_cycle();
        n_vec++;
        if (acc_q.size() !== 1 || acc_at(0) !== 8'h11 || ferr_cnt !== 1) begin
            n_err++; $display("FAIL ferr_recover: got n=%0d %h ferr=%0d want 1 11 1",
                              acc_q.size(), acc_at(0), ferr_cnt);
        end
    endtask

    task automatic test_overrun();
        int tb2;
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tb2 = t0;
        repeat (4) wait_cycle();
        n_vec++;
        if (ovr_cnt !== 1 || ovr_cyc !== tb2 + 39) begin
            n_err++; $display("FAIL ovr_pulse: got %0d pulses at %0d want 1 at %0d",
                              ovr_cnt, ovr_cyc, tb2 + 39);
        end
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h12) begin
            n_err++; $display("FAIL ovr_hold: got v=%b data=%h want 1 12", valid_o, data_o);
        end
        ready_i = 1'b1;
        wait_cycle();
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_err++; $display("FAIL ovr_drain: got valid=%b want 0", valid_o);
        end
        n_vec++;
        if (acc_q.size() !== 1 || acc_at(0) !== 8'h12 || ferr_cnt !== 0) begin
            n_err++; $display("FAIL ovr_consumed: got n=%0d %h ferr=%0d want 1 12 0",
                              acc_q.size(), acc_at(0), ferr_cnt);
        end
    endtask

    task automatic test_same_edge();
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h56, 1'b1);
        repeat (3) wait_cycle();
        fork
            send_frame(8'h9C, 1'b1);
            begin
                int guard;
                guard = 0;
                wait_cycle();
                while (cyc < t0 + 38 && guard < 200) begin
                    wait_cycle();
                    guard++;
                end
                ready_i = 1'b1;
                wait_cycle();
                ready_i = 1'b0;
            end
        join
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h9C) begin
            n_err++; $display("FAIL same_edge_load: got v=%b data=%h want 1 9c", valid_o, data_o);
        end
        n_vec++;
        if (ovr_cnt !== 0 || acc_q.size() !== 1 || acc_at(0) !== 8'h56) begin
            n_err++; $display("FAIL same_edge_no_ovr: got ovr=%0d n=%0d %h want 0 1 56",
                              ovr_cnt, acc_q.size(), acc_at(0));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h77;
        ready_i = 1'b0;
        line = 1'b0;
        repeat (CPB) wait_cycle();
        for (int i = 0; i < 4; i++) begin
            line = b[i];
            repeat (CPB) wait_cycle();
        end
        line = b[4];
        repeat (2) wait_cycle();
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({data_o, valid_o, frame_err_o, overrun_o} !== 11'h0) begin
            n_err++; $display("FAIL midreset_outputs: got data=%h v=%b fe=%b ov=%b want all 0",
                              data_o, valid_o, frame_err_o, overrun_o);
        end
        line = 1'b1;
        repeat (2) wait_cycle();
        rstn = 1'b1;
        repeat (10) wait_cycle();
        clear_mon();
        ready_i = 1'b1;
        send_frame(8'hC3, 1'b1);
        repeat (6) wait_cycle();
        n_vec++;
        if (acc_q.size() !== 1 || acc_at(0) !== 8'hC3 || ferr_cnt + ovr_cnt !== 0) begin
            n_err++; $display("FAIL midreset_next_frame: got n=%0d %h errs=%0d want 1 c3 0",
                              acc_q.size(), acc_at(0), ferr_cnt + ovr_cnt);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        both_cnt = 0;
        t0       = 0;
        rstn     = 1'b0;
        line     = 1'b1;
        ready_i  = 1'b1;
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_same_edge();
        test_reset_mid();
        n_vec++;
        if (both_cnt !== 0) begin
            n_err++; $display("FAIL err_exclusive: got %0d coincident pulses want 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
